// File: rtl/rr_mux.sv
// N-channel registered multiplexer with valid/ready handshaking.
// Source chosen per cycle by round-robin arbitration (mode 0) or explicit selector (mode 1).
module rr_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int NP = 2 ** SW;

    logic [SW-1:0]    ptr;
    logic             load;
    logic             grant_valid;
    logic [SW-1:0]    grant;
    logic [WIDTH-1:0] grant_data;
    logic             xfer_ok;

    logic             rr_valid;
    logic [SW-1:0]    rr_idx;
    logic [SW:0]      rr_sum;
    logic [SW-1:0]    rr_cand;
    logic             sel_ok;

    // Valid bits padded to a power of two so any SW-bit index is in range;
    // unused slots read as 0 and can never be granted.
    logic [NP-1:0]    valid_pad;

    assign valid_pad = NP'(in_valid);
    assign load      = !out_valid || out_ready;
    assign xfer_ok   = load && grant_valid && !rst;
    assign sel_ok    = ({1'b0, sel} < (SW+1)'(N));

    // Search ptr+1 .. ptr+N, wrapping at N-1 -> 0 without visiting unused indices.
    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int unsigned k = 1; k <= unsigned'(N); k++) begin
            rr_sum = {1'b0, ptr} + (SW+1)'(k);
            if (rr_sum >= (SW+1)'(N)) begin
                rr_sum = rr_sum - (SW+1)'(N);
            end
            rr_cand = rr_sum[SW-1:0];
            if (!rr_valid && valid_pad[rr_cand]) begin
                rr_valid = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant       = sel;
            grant_valid = sel_ok && valid_pad[sel];
        end else begin
            grant       = rr_idx;
            grant_valid = rr_valid;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < unsigned'(N); i++) begin
            if (grant == SW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < unsigned'(N); i++) begin
            in_ready[i] = xfer_ok && (grant == SW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SW'(N - 1);
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant;
                ptr       <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux: N=4 instance for most scenarios,
// N=3 instance for non-power-of-two wrap behaviour.
module tb_rr_mux;

    logic         clk;
    logic         rst;

    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_valid3;
    logic         out_ready3;

    int compared;
    int mismatched;

    rr_mux #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_mux #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid3 = 3'b111;
        out_ready3 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid  = 4'($urandom());
            mode      = 1'($urandom());
            sel       = 2'($urandom());
            out_ready = 1'($urandom());
            @(posedge clk);
            #1;
        end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++;
        if (out_data !== 32'h0) begin mismatched++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        compared++;
        if (out_sel !== 2'd0) begin mismatched++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
        in_valid = 4'b1111;
        mode     = 1'b0;
        #1;
        compared++;
        if (in_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        compared++;
        if (in_ready3 !== 3'b000) begin mismatched++; $display("FAIL reset_in_ready3: got %b want 000", in_ready3); end

        in_valid       = 4'b0001;
        in_data        = '0;
        in_data[31:0]  = 32'h1;
        out_ready      = 1'b1;
        in_valid3      = 3'b000;
        rst            = 1'b0;
        #1;
        compared++;
        if (in_ready !== 4'b0001) begin mismatched++; $display("FAIL release_in_ready: got %b want 0001", in_ready); end
        @(posedge clk);
        #1;
        compared++;
        if (out_data !== 32'h1) begin mismatched++; $display("FAIL release_out_data: got %h want 1", out_data); end
        compared++;
        if (out_sel !== 2'd0) begin mismatched++; $display("FAIL release_out_sel: got %0d want 0", out_sel); end
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL release_out_valid: got %b want 1", out_valid); end
    endtask

    task automatic test_round_robin();
        in_valid = 4'b0000;
        do_reset();
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        in_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            int e;
            e = c % 4;
            #1;
            compared++;
            if (in_ready !== 4'(1 << e)) begin mismatched++; $display("FAIL rr_in_ready[%0d]: got %b want %b", c, in_ready, 4'(1 << e)); end
            @(posedge clk);
            #1;
            compared++;
            if (out_sel !== 2'(e)) begin mismatched++; $display("FAIL rr_out_sel[%0d]: got %0d want %0d", c, out_sel, e); end
            compared++;
            if (out_data !== 32'hA0 + 32'(e)) begin mismatched++; $display("FAIL rr_out_data[%0d]: got %h want %h", c, out_data, 32'hA0 + 32'(e)); end
        end
    endtask

    task automatic test_fixed();
        mode           = 1'b1;
        out_ready      = 1'b1;
        in_data        = '0;
        in_data[63:32] = 32'h1;
        in_valid       = 4'b0011;
        sel            = 2'd0;
        @(posedge clk);
        #1;
        compared++;
        if (out_data !== 32'h0 || out_sel !== 2'd0 || out_valid !== 1'b1) begin
            mismatched++; $display("FAIL fixed_sel0: got data=%h sel=%0d v=%b want 0/0/1", out_data, out_sel, out_valid);
        end
        sel = 2'd1;
        @(posedge clk);
        #1;
        compared++;
        if (out_data !== 32'h1 || out_sel !== 2'd1 || out_valid !== 1'b1) begin
            mismatched++; $display("FAIL fixed_sel1: got data=%h sel=%0d v=%b want 1/1/1", out_data, out_sel, out_valid);
        end
        sel = 2'd3;
        #1;
        compared++;
        if (in_ready !== 4'b0000) begin mismatched++; $display("FAIL fixed_sel3_ready: got %b want 0000", in_ready); end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL fixed_sel3_valid: got %b want 0", out_valid); end
        compared++;
        if (out_data !== 32'h1) begin mismatched++; $display("FAIL fixed_sel3_hold: got %h want 1", out_data); end
    endtask

    task automatic test_back_pressure();
        in_valid = 4'b0000;
        mode     = 1'b0;
        do_reset();
        in_data            = '0;
        in_data[31:0]      = 32'h55;
        in_data[95:64]     = 32'h77;
        in_valid           = 4'b0001;
        out_ready          = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (out_data !== 32'h55 || out_valid !== 1'b1) begin
            mismatched++; $display("FAIL bp_first: got data=%h v=%b want 55/1", out_data, out_valid);
        end
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++;
            if (in_ready !== 4'b0000) begin mismatched++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, in_ready); end
            @(posedge clk);
            #1;
            compared++;
            if (out_data !== 32'h55 || out_sel !== 2'd0 || out_valid !== 1'b1) begin
                mismatched++; $display("FAIL bp_stall_hold[%0d]: got data=%h sel=%0d v=%b want 55/0/1", c, out_data, out_sel, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 4'b0100) begin mismatched++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
        @(posedge clk);
        #1;
        compared++;
        if (out_data !== 32'h77 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
            mismatched++; $display("FAIL bp_release_load: got data=%h sel=%0d v=%b want 77/2/1", out_data, out_sel, out_valid);
        end
    endtask

    task automatic test_wrap();
        in_valid  = 4'b0000;
        in_valid3 = 3'b000;
        do_reset();
        for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'h30 + 32'(i);
        mode3      = 1'b0;
        out_ready3 = 1'b1;
        in_valid3  = 3'b010;
        #1;
        compared++;
        if (in_ready3 !== 3'b010) begin mismatched++; $display("FAIL wrap_ready_a: got %b want 010", in_ready3); end
        @(posedge clk);
        #1;
        compared++;
        if (out_sel3 !== 2'd1 || out_data3 !== 32'h31) begin mismatched++; $display("FAIL wrap_grant_a: got sel=%0d data=%h want 1/31", out_sel3, out_data3); end
        in_valid3 = 3'b101;
        #1;
        compared++;
        if (in_ready3 !== 3'b100) begin mismatched++; $display("FAIL wrap_ready_b: got %b want 100", in_ready3); end
        @(posedge clk);
        #1;
        compared++;
        if (out_sel3 !== 2'd2 || out_data3 !== 32'h32) begin mismatched++; $display("FAIL wrap_grant_b: got sel=%0d data=%h want 2/32", out_sel3, out_data3); end
        #1;
        compared++;
        if (in_ready3 !== 3'b001) begin mismatched++; $display("FAIL wrap_ready_c: got %b want 001", in_ready3); end
        @(posedge clk);
        #1;
        compared++;
        if (out_sel3 !== 2'd0 || out_data3 !== 32'h30) begin mismatched++; $display("FAIL wrap_grant_c: got sel=%0d data=%h want 0/30", out_sel3, out_data3); end
        mode3     = 1'b1;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        #1;
        compared++;
        if (in_ready3 !== 3'b000) begin mismatched++; $display("FAIL wrap_sel3_ready: got %b want 000", in_ready3); end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid3 !== 1'b0) begin mismatched++; $display("FAIL wrap_sel3_valid: got %b want 0", out_valid3); end
        in_valid3 = 3'b000;
        mode3     = 1'b0;
    endtask

    task automatic test_async_reset();
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        in_valid = 4'b1111;
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL async_pre_valid: got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            mismatched++; $display("FAIL async_immediate: got v=%b data=%h want 0/0", out_valid, out_data);
        end
        compared++;
        if (in_ready !== 4'b0000) begin mismatched++; $display("FAIL async_in_ready: got %b want 0000", in_ready); end
        #1;
        rst = 1'b0;
        #1;
        compared++;
        if (in_ready !== 4'b0001) begin mismatched++; $display("FAIL async_restart_ready: got %b want 0001", in_ready); end
        @(posedge clk);
        #1;
        compared++;
        if (out_sel !== 2'd0 || out_data !== 32'hA0 || out_valid !== 1'b1) begin
            mismatched++; $display("FAIL async_restart_grant: got sel=%0d data=%h v=%b want 0/a0/1", out_sel, out_data, out_valid);
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        mode       = 1'b0;
        sel        = '0;
        out_ready  = 1'b0;
        in_data3   = '0;
        in_valid3  = '0;
        mode3      = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b0;
        compared   = 0;
        mismatched = 0;

        test_reset();
        test_round_robin();
        test_fixed();
        test_back_pressure();
        test_wrap();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
